dt_engine: RTL and testbench

Table-driven decision-tree classifier for the sensor-classification path. It evaluates any binary tree of IEEE-754 single-precision threshold comparisons over `NUM_FEATURES` input features. The tree lives in a runtime-writable node table, so it replaces hard-coded per-model tree FSMs. It sits between the feature-extraction stage and the class-result consumer, using the same `start`/`busy`/`valid` handshake as the existing classifier blocks.

---
 rtl/dt_engine.sv | 122 ++++++++++++
 tb/tb_dt_engine.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dt_engine.sv
// Table-driven decision-tree classifier: walks a runtime-written node table of float threshold tests.
// States: IDLE (wait start edge) | FETCH (read node) | EVAL (float compare, pick child) | DONE (result strobe)
module dt_engine #(
    parameter int NUM_FEATURES = 5,
    parameter int FIDX_W       = 3,
    parameter int NODE_AW      = 4,
    parameter int CLASS_W      = 3,
    localparam int NODE_W      = 1 + FIDX_W + 32 + 2 * NODE_AW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [NUM_FEATURES*32-1:0] features,
    input  logic                       cfg_we,
    input  logic [NODE_AW-1:0]         cfg_addr,
    input  logic [NODE_W-1:0]          cfg_wdata,
    output logic [CLASS_W-1:0]         class_id,
    output logic                       busy,
    output logic                       valid,
    output logic                       err
);

    typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_t;

    localparam logic [FIDX_W:0]  NF        = NUM_FEATURES[FIDX_W:0];
    localparam logic [NODE_AW:0] MAX_STEPS = {1'b1, {NODE_AW{1'b0}}};

    state_t              state, state_next;
    logic                start_q;
    logic [31:0]         feat_q [NUM_FEATURES];
    logic [NODE_W-1:0]   tbl [2**NODE_AW];
    logic [NODE_AW-1:0]  ptr;
    logic [NODE_AW:0]    steps;
    logic [31:0]         op_a, op_b;

    logic                start_edge;
    logic [NODE_W-1:0]   node;
    logic                node_leaf;
    logic [FIDX_W-1:0]   node_fidx;
    logic [31:0]         node_thr;
    logic [NODE_AW-1:0]  node_tnext, node_fnext;
    logic                bad_idx, guard_hit;

    // Signed float a >= b on raw bits; +0 and -0 are equal, NaN is not special.
    function automatic logic fge(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31])
            return (a[30:0] == '0 && b[30:0] == '0) ? 1'b1 : !a[31];
        else if (!a[31])
            return a[30:0] >= b[30:0];
        else
            return a[30:0] <= b[30:0];
    endfunction

    assign start_edge = start && !start_q;
    assign node       = tbl[ptr];
    assign node_leaf  = node[NODE_W-1];
    assign node_fidx  = node[NODE_W-2 -: FIDX_W];
    assign node_thr   = node[2*NODE_AW +: 32];
    assign node_tnext = node[NODE_AW +: NODE_AW];
    assign node_fnext = node[0 +: NODE_AW];
    assign bad_idx    = {1'b0, node_fidx} >= NF;
    assign guard_hit  = steps == MAX_STEPS;

    assign busy  = (state == FETCH) || (state == EVAL);
    assign valid = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_edge) state_next = FETCH;
            FETCH:   state_next = (node_leaf || bad_idx || guard_hit) ? DONE : EVAL;
            EVAL:    state_next = FETCH;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            start_q  <= 1'b0;
            class_id <= '0;
            err      <= 1'b0;
            ptr      <= '0;
            steps    <= '0;
            op_a     <= '0;
            op_b     <= '0;
            for (int i = 0; i < NUM_FEATURES; i++) feat_q[i] <= '0;
            for (int i = 0; i < 2**NODE_AW; i++) tbl[i] <= '0;
        end else begin
            state   <= state_next;
            start_q <= start;
            // Table is frozen while a traversal owns it.
            if (state == IDLE && cfg_we) tbl[cfg_addr] <= cfg_wdata;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        for (int i = 0; i < NUM_FEATURES; i++) feat_q[i] <= features[32*i +: 32];
                        ptr   <= '0;
                        steps <= '0;
                    end
                end
                FETCH: begin
                    steps <= steps + 1'b1;
                    if (node_leaf) begin
                        class_id <= node_thr[CLASS_W-1:0];
                        err      <= 1'b0;
                    end else if (bad_idx || guard_hit) begin
                        class_id <= '0;
                        err      <= 1'b1;
                    end else begin
                        op_a <= feat_q[node_fidx];
                        op_b <= node_thr;
                    end
                end
                EVAL:    ptr <= fge(op_a, op_b) ? node_tnext : node_fnext;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dt_engine.sv
// Directed bench for dt_engine: latency, class/err results, float sign rules and handshake corner cases.
module tb_dt_engine;

    localparam int NF = 5;
    localparam int FW = 3;
    localparam int AW = 4;
    localparam int CW = 3;
    localparam int NW = 1 + FW + 32 + 2 * AW;

    logic            clk, rst, start, cfg_we;
    logic [NF*32-1:0] features;
    logic [AW-1:0]   cfg_addr;
    logic [NW-1:0]   cfg_wdata;
    logic [CW-1:0]   class_id;
    logic            busy, valid, err;

    int n_assert = 0;
    int n_fail   = 0;

    dt_engine #(.NUM_FEATURES(NF), .FIDX_W(FW), .NODE_AW(AW), .CLASS_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .features(features),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .class_id(class_id), .busy(busy), .valid(valid), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [NW-1:0] mk_node(input logic leaf, input logic [FW-1:0] fidx,
                                              input logic [31:0] thr, input logic [AW-1:0] tn,
                                              input logic [AW-1:0] fn);
        return {leaf, fidx, thr, tn, fn};
    endfunction

    function automatic logic [NF*32-1:0] fv(input logic [31:0] f1, input logic [31:0] f2);
        return {32'h0, 32'h0, f2, f1, 32'h0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_node(input logic [AW-1:0] addr, input logic [NW-1:0] data);
        cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Called at a negedge with start low. Raises start, optionally injects a table write,
    // a feature change or a second start edge at given cycles, then checks the result.
    task automatic do_run(input string tag, input logic [CW-1:0] exp_class, input logic exp_err,
                          input int exp_cyc, input int we_cyc, input logic [AW-1:0] waddr,
                          input logic [NW-1:0] wdata, input int chg_cyc,
                          input logic [NF*32-1:0] chg_feat, input int restart_cyc);
        int  cyc;
        int  busy_cnt;
        logic seen;
        cyc = 0; busy_cnt = 0; seen = 1'b0;
        start = 1'b1;
        if (we_cyc == 0) begin cfg_we = 1'b1; cfg_addr = waddr; cfg_wdata = wdata; end
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            cfg_we = 1'b0;
            if (cyc == we_cyc) begin cfg_we = 1'b1; cfg_addr = waddr; cfg_wdata = wdata; end
            if (cyc == chg_cyc) features = chg_feat;
            if (cyc == restart_cyc) start = 1'b0;
            if (cyc == restart_cyc + 1) start = 1'b1;
            if (valid) break;
            if (busy) busy_cnt++;
        end
        cfg_we = 1'b0;
        chk({tag, " latency"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, " class"}, 64'(class_id), 64'(exp_class));
        chk({tag, " err"}, 64'(err), 64'(exp_err));
        chk({tag, " busy at valid"}, 64'(busy), 64'd0);
        chk({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_cyc - 1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen = seen | valid | busy;
        end
        chk({tag, " no retrigger"}, 64'(seen), 64'd0);
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic plain_run(input string tag, input logic [CW-1:0] exp_class,
                             input logic exp_err, input int exp_cyc);
        do_run(tag, exp_class, exp_err, exp_cyc, -1, '0, '0, -1, '0, -1);
    endtask

    initial begin
        logic seen;
        rst = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; features = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset class", 64'(class_id), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset valid", 64'(valid), 64'd0);
        chk("reset err", 64'(err), 64'd0);

        plain_run("unprogrammed", 3'd0, 1'b1, 34);

        write_node(4'd0, mk_node(1'b0, 3'd2, 32'h3F000001, 4'd1, 4'd2));
        write_node(4'd1, mk_node(1'b1, 3'd0, 32'd0, 4'd0, 4'd0));
        write_node(4'd2, mk_node(1'b0, 3'd1, 32'h3F2E147C, 4'd3, 4'd4));
        write_node(4'd3, mk_node(1'b1, 3'd0, 32'd4, 4'd0, 4'd0));
        write_node(4'd4, mk_node(1'b1, 3'd0, 32'd5, 4'd0, 4'd0));

        features = fv(32'h0, 32'h3F800000);
        plain_run("tree f2=1.0", 3'd0, 1'b0, 4);
        features = fv(32'h3F800000, 32'h3E800000);
        plain_run("tree f1=1.0", 3'd4, 1'b0, 6);
        features = fv(32'h3E800000, 32'h3E800000);
        plain_run("tree f1=0.25", 3'd5, 1'b0, 6);

        write_node(4'd0, mk_node(1'b0, 3'd2, 32'hBF800000, 4'd1, 4'd2));
        features = fv(32'h3F800000, 32'hC0000000);
        plain_run("neg -2 vs -1", 3'd4, 1'b0, 6);
        features = fv(32'h3F800000, 32'h80000000);
        plain_run("neg -0 vs -1", 3'd0, 1'b0, 4);
        // Write to node0 lands on the same edge as start; new threshold +0.0 must be used.
        features = fv(32'h3F800000, 32'h80000001);
        do_run("same-edge write", 3'd4, 1'b0, 6, 0, 4'd0,
               mk_node(1'b0, 3'd2, 32'h00000000, 4'd1, 4'd2), -1, '0, -1);
        features = fv(32'h3F800000, 32'h80000000);
        plain_run("-0 vs +0", 3'd0, 1'b0, 4);

        write_node(4'd0, mk_node(1'b0, 3'd7, 32'h0, 4'd1, 4'd2));
        plain_run("bad fidx", 3'd0, 1'b1, 2);

        write_node(4'd0, mk_node(1'b0, 3'd2, 32'h3F000001, 4'd1, 4'd2));
        features = fv(32'h3F800000, 32'h3F800000);
        do_run("busy write+restart", 3'd0, 1'b0, 4, 2, 4'd0,
               mk_node(1'b1, 3'd0, 32'd7, 4'd0, 4'd0), -1, '0, 1);
        plain_run("table unchanged", 3'd0, 1'b0, 4);

        features = fv(32'h3F800000, 32'h3E800000);
        do_run("feature snapshot", 3'd4, 1'b0, 6, -1, '0, '0, 2,
               fv(32'h3E800000, 32'h3F800000), -1);

        features = fv(32'h3F800000, 32'h3E800000);
        start = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst valid", 64'(valid), 64'd0);
        chk("midrst class", 64'(class_id), 64'd0);
        chk("midrst err", 64'(err), 64'd0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | valid | busy;
        end
        chk("midrst no valid", 64'(seen), 64'd0);
        plain_run("table cleared", 3'd0, 1'b1, 34);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
